// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writers and picks bypass sources per read port.
// Optional FWD_STATS_EN macro adds stall-cycle and forwarding-event counters.
module fwd_scoreboard #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NPORT = 2,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_addr,
  input  logic [1:0]             issue_tnew,
  input  logic                   flush,
  input  logic [DEPTH*DW-1:0]    stg_data,
  input  logic [NPORT*AW-1:0]    rd_addr,
  input  logic [NPORT*2-1:0]     rd_tuse,
  input  logic [NPORT*DW-1:0]    rf_data,
  output logic [NPORT*DW-1:0]    fwd_data,
  output logic [NPORT*2-1:0]     fwd_sel,
  output logic [NPORT-1:0]       pending,
  output logic                   stall,
  output logic [31:0]            stat_stall,
  output logic [31:0]            stat_fwd
);

  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [1:0]       ent_tnew [DEPTH];

  function automatic logic [1:0] dec2(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Entries advance every cycle, even while stalled; the issue slot also counts as one move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        ent_addr[s] <= '0;
        ent_tnew[s] <= '0;
      end
    end else if (flush) begin
      ent_valid <= '0;
    end else begin
      ent_valid[0] <= issue_valid && !stall && (issue_addr != '0);
      ent_addr[0]  <= issue_addr;
      ent_tnew[0]  <= dec2(issue_tnew);
      for (int s = 1; s < DEPTH; s++) begin
        ent_valid[s] <= ent_valid[s-1];
        ent_addr[s]  <= ent_addr[s-1];
        ent_tnew[s]  <= dec2(ent_tnew[s-1]);
      end
    end
  end

  always_comb begin
    logic            hit;
    logic [1:0]      hit_tnew;
    logic [1:0]      hit_sel;
    logic [DW-1:0]   hit_data;
    logic [AW-1:0]   ra;
    logic [1:0]      tu;
    stall    = 1'b0;
    fwd_data = rf_data;
    fwd_sel  = '0;
    pending  = '0;
    for (int p = 0; p < NPORT; p++) begin
      ra       = rd_addr[p*AW +: AW];
      tu       = rd_tuse[p*2 +: 2];
      hit      = 1'b0;
      hit_tnew = 2'd0;
      hit_sel  = 2'd0;
      hit_data = '0;
      // Scan oldest to youngest so the youngest match overwrites any older one.
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (ent_valid[s] && (ra != '0) && (ent_addr[s] == ra)) begin
          hit      = 1'b1;
          hit_tnew = ent_tnew[s];
          hit_sel  = 2'(s + 1);
          hit_data = stg_data[s*DW +: DW];
        end
      end
      if (hit) begin
        if (hit_tnew == 2'd0) begin
          fwd_data[p*DW +: DW] = hit_data;
          fwd_sel[p*2 +: 2]    = hit_sel;
        end else if (hit_tnew <= tu) begin
          pending[p] = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt;

  always_comb begin
    fwd_cnt = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (fwd_sel[p*2 +: 2] != 2'd0) fwd_cnt = fwd_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_stall <= '0;
      stat_fwd   <= '0;
    end else begin
      if (stall) stat_stall <= stat_stall + 32'd1;
      stat_fwd <= stat_fwd + fwd_cnt;
    end
  end
`else
  assign stat_stall = '0;
  assign stat_fwd   = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus a random run against
// a model that tracks each in-flight writer by its issue tnew and its age.
module tb_fwd_scoreboard;

  localparam int DW = 32, AW = 5, NPORT = 2, DEPTH = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic [1:0]           issue_tnew;
  logic                 flush;
  logic [DEPTH*DW-1:0]  stg_data;
  logic [NPORT*AW-1:0]  rd_addr;
  logic [NPORT*2-1:0]   rd_tuse;
  logic [NPORT*DW-1:0]  rf_data;
  logic [NPORT*DW-1:0]  fwd_data;
  logic [NPORT*2-1:0]   fwd_sel;
  logic [NPORT-1:0]     pending;
  logic                 stall;
  logic [31:0]          stat_stall;
  logic [31:0]          stat_fwd;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per age slot, the writer's address and the tnew it was issued with.
  logic          m_valid [DEPTH];
  logic [AW-1:0] m_addr  [DEPTH];
  int            m_tnew0 [DEPTH];
  logic [31:0]   m_st, m_fw;
  logic [DW-1:0] e_data  [NPORT];
  int            e_sel   [NPORT];
  logic          e_pend  [NPORT];
  logic          e_stall;

  fwd_scoreboard #(.DW(DW), .AW(AW), .NPORT(NPORT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_tnew(issue_tnew), .flush(flush), .stg_data(stg_data), .rd_addr(rd_addr),
    .rd_tuse(rd_tuse), .rf_data(rf_data), .fwd_data(fwd_data), .fwd_sel(fwd_sel),
    .pending(pending), .stall(stall), .stat_stall(stat_stall), .stat_fwd(stat_fwd)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int s = 0; s < DEPTH; s++) begin
      m_valid[s] = 1'b0; m_addr[s] = '0; m_tnew0[s] = 0;
    end
  endtask

  task automatic model_eval();
    e_stall = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      logic [AW-1:0] ra;
      int tu, rem;
      bit found;
      ra = rd_addr[p*AW +: AW];
      tu = int'(rd_tuse[p*2 +: 2]);
      e_sel[p] = 0; e_pend[p] = 1'b0; e_data[p] = rf_data[p*DW +: DW];
      found = 0;
      for (int s = 0; s < DEPTH; s++) begin
        if (!found && m_valid[s] && ra != 0 && m_addr[s] == ra) begin
          found = 1;
          rem = (m_tnew0[s] > s + 1) ? m_tnew0[s] - (s + 1) : 0;
          if (rem == 0) begin
            e_sel[p] = s + 1; e_data[p] = stg_data[s*DW +: DW];
          end else if (rem <= tu) e_pend[p] = 1'b1;
          else e_stall = 1'b1;
        end
      end
    end
  endtask

  // One clock: the model ages its writers using the inputs present at the edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (e_stall) m_st = m_st + 32'd1;
    for (int p = 0; p < NPORT; p++) if (e_sel[p] != 0) m_fw = m_fw + 32'd1;
    if (flush) model_clear();
    else begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        m_valid[s] = m_valid[s-1]; m_addr[s] = m_addr[s-1]; m_tnew0[s] = m_tnew0[s-1];
      end
      m_valid[0] = issue_valid && !e_stall && issue_addr != 0;
      m_addr[0]  = issue_addr;
      m_tnew0[0] = int'(issue_tnew);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_addr = '0; issue_tnew = '0; flush = 0;
    rd_addr = '0; rd_tuse = '0;
    stg_data = {$urandom, $urandom, $urandom};
    rf_data  = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [1:0] t);
    idle_inputs();
    issue_valid = 1; issue_addr = a; issue_tnew = t;
    tick();
    issue_valid = 0;
  endtask

  task automatic clear_pipe();
    idle_inputs(); flush = 1; tick(); flush = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    model_clear(); m_st = 0; m_fw = 0;
    idle_inputs();
    issue_valid = 1; issue_addr = 5'd3; issue_tnew = 2'd0;
    rd_addr = {5'd3, 5'd3};
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL reset_pending got %b want 00", pending); end
    n_checks++; if (fwd_sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel got %h want 0", fwd_sel); end
    n_checks++; if (fwd_data !== rf_data) begin n_fail++; $display("FAIL reset_data got %h want %h", fwd_data, rf_data); end
    n_checks++; if (stat_stall !== 32'd0 || stat_fwd !== 32'd0) begin n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_stall, stat_fwd); end
    @(negedge clk);
    reset = 1;
    idle_inputs();
  endtask

  task automatic test_forward_basic();
    clear_pipe();
    issue(5'd8, 2'd0);
    rd_addr = {5'd0, 5'd8};
    stg_data[DW-1:0] = 32'h1234;
    #1;
    n_checks++; if (fwd_sel[1:0] !== 2'd1) begin n_fail++; $display("FAIL fwd_basic_sel got %0d want 1", fwd_sel[1:0]); end
    n_checks++; if (fwd_data[DW-1:0] !== 32'h1234) begin n_fail++; $display("FAIL fwd_basic_data got %h want 00001234", fwd_data[DW-1:0]); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_basic_stall got %b want 0", stall); end
    tick();
  endtask

  task automatic test_stall_release();
    clear_pipe();
    issue(5'd9, 2'd2);
    rd_addr = {5'd0, 5'd9}; rd_tuse = '0;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_first got %b want 1", stall); end
    tick();
    rd_addr = {5'd0, 5'd9}; rd_tuse = '0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_second got %b want 0", stall); end
    n_checks++; if (fwd_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL stall_sel got %0d want 2", fwd_sel[1:0]); end
    n_checks++; if (fwd_data[DW-1:0] !== stg_data[2*DW-1:DW]) begin n_fail++; $display("FAIL stall_data got %h want %h", fwd_data[DW-1:0], stg_data[2*DW-1:DW]); end
    tick();
  endtask

  task automatic test_younger_pending();
    clear_pipe();
    issue(5'd10, 2'd0);
    issue(5'd10, 2'd2);
    rd_addr = {5'd0, 5'd10}; rd_tuse = {2'd0, 2'd1};
    #1;
    n_checks++; if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL young_pending got %b want 1", pending[0]); end
    n_checks++; if (fwd_sel[1:0] !== 2'd0) begin n_fail++; $display("FAIL young_sel got %0d want 0", fwd_sel[1:0]); end
    n_checks++; if (fwd_data[DW-1:0] !== rf_data[DW-1:0]) begin n_fail++; $display("FAIL young_data got %h want %h", fwd_data[DW-1:0], rf_data[DW-1:0]); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL young_stall got %b want 0", stall); end
    tick();
  endtask

  task automatic test_zero_reg();
    clear_pipe();
    issue(5'd0, 2'd0);
    rd_addr = {5'd0, 5'd0};
    #1;
    n_checks++; if (fwd_sel !== 4'd0) begin n_fail++; $display("FAIL zero_sel got %h want 0", fwd_sel); end
    n_checks++; if (fwd_data !== rf_data) begin n_fail++; $display("FAIL zero_data got %h want %h", fwd_data, rf_data); end
    tick();
  endtask

  task automatic test_flush();
    clear_pipe();
    issue(5'd11, 2'd3);
    issue(5'd12, 2'd3);
    issue(5'd13, 2'd3);
    rd_addr = {5'd11, 5'd13}; rd_tuse = '0;
    flush = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall got %b want 1", stall); end
    n_checks++; if (fwd_sel[3:2] !== 2'd3) begin n_fail++; $display("FAIL flush_pre_sel1 got %0d want 3", fwd_sel[3:2]); end
    tick();
    flush = 0;
    rd_addr = {5'd11, 5'd13};
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", stall); end
    n_checks++; if (fwd_sel !== 4'd0 || pending !== 2'b00) begin n_fail++; $display("FAIL flush_match got sel %h pend %b want 0/00", fwd_sel, pending); end
    rd_addr = {5'd0, 5'd12};
    #1;
    n_checks++; if (fwd_sel !== 4'd0 || pending !== 2'b00 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_mid got sel %h pend %b stall %b want 0", fwd_sel, pending, stall); end
    tick();
  endtask

  task automatic test_stats();
    logic [31:0] want_st, want_fw;
    clear_pipe();
    reset = 0; #1; reset = 1;
    m_st = 0; m_fw = 0; model_clear();
    // Two writers needing two stall cycles each, one needing a single stall cycle.
    for (int k = 0; k < 3; k++) begin
      issue(5'(16 + k), (k == 2) ? 2'd2 : 2'd3);
      for (int c = 0; c < ((k == 2) ? 1 : 2); c++) begin
        rd_addr = {5'd0, 5'(16 + k)}; rd_tuse = '0;
        tick();
      end
      idle_inputs();
      repeat (2) tick();
    end
    issue(5'd20, 2'd0);
    for (int c = 0; c < 3; c++) begin
      rd_addr = {5'd20, 5'd20}; rd_tuse = '0;
      tick();
    end
    idle_inputs();
    #1;
`ifdef FWD_STATS_EN
    want_st = 32'd5; want_fw = 32'd6;
`else
    want_st = 32'd0; want_fw = 32'd0;
`endif
    n_checks++; if (stat_stall !== want_st) begin n_fail++; $display("FAIL stats_stall got %0d want %0d", stat_stall, want_st); end
    n_checks++; if (stat_fwd !== want_fw) begin n_fail++; $display("FAIL stats_fwd got %0d want %0d", stat_fwd, want_fw); end
    #2 reset = 0;
    #1;
    n_checks++; if (stat_stall !== 32'd0 || stat_fwd !== 32'd0) begin n_fail++; $display("FAIL stats_reset got %0d/%0d want 0/0", stat_stall, stat_fwd); end
    model_clear(); m_st = 0; m_fw = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_random();
    logic [31:0] want_st, want_fw;
    for (int i = 0; i < 400; i++) begin
      issue_valid = 1'($urandom);
      issue_addr  = 5'($urandom_range(0, 7));
      issue_tnew  = 2'($urandom);
      flush       = ($urandom_range(0, 15) == 0);
      rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_tuse     = 4'($urandom);
      stg_data    = {$urandom, $urandom, $urandom};
      rf_data     = {$urandom, $urandom};
      #1;
      model_eval();
`ifdef FWD_STATS_EN
      want_st = m_st; want_fw = m_fw;
`else
      want_st = 32'd0; want_fw = 32'd0;
`endif
      n_checks++; if (stall !== e_stall) begin n_fail++; $display("FAIL rand_stall cyc %0d got %b want %b", i, stall, e_stall); end
      for (int p = 0; p < NPORT; p++) begin
        n_checks++; if (fwd_sel[p*2 +: 2] !== 2'(e_sel[p])) begin n_fail++; $display("FAIL rand_sel%0d cyc %0d got %0d want %0d", p, i, fwd_sel[p*2 +: 2], e_sel[p]); end
        n_checks++; if (fwd_data[p*DW +: DW] !== e_data[p]) begin n_fail++; $display("FAIL rand_data%0d cyc %0d got %h want %h", p, i, fwd_data[p*DW +: DW], e_data[p]); end
        n_checks++; if (pending[p] !== e_pend[p]) begin n_fail++; $display("FAIL rand_pend%0d cyc %0d got %b want %b", p, i, pending[p], e_pend[p]); end
      end
      n_checks++; if (stat_stall !== want_st || stat_fwd !== want_fw) begin n_fail++; $display("FAIL rand_stats cyc %0d got %0d/%0d want %0d/%0d", i, stat_stall, stat_fwd, want_st, want_fw); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forward_basic();
    test_stall_release();
    test_younger_pending();
    test_zero_reg();
    test_flush();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter DW, default 32, meaning datapath width.
REQ-002 SHALL have parameter AW, default 5, meaning register-address width.
REQ-003 SHALL have parameter NPORT, default 2, meaning number of read ports.
REQ-004 SHALL have parameter DEPTH, default 3, meaning number of tracked producer stages after issue, with stage 0 the youngest.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port issue_valid  input  1  instruction leaving decode writes a register.
REQ-008 SHALL have port issue_addr  input  AW  destination register.
REQ-009 SHALL have port issue_tnew  input  2  cycles until the result exists at its producing stage.
REQ-010 SHALL have port flush  input  1  discard all tracked entries.
REQ-011 SHALL have port stg_data  input  DEPTH*DW  result bus of each stage, slice s = stage s.
REQ-012 SHALL have port rd_addr  input  NPORT*AW  source register per port.
REQ-013 SHALL have port rd_tuse  input  NPORT*2  cycles until each port needs its operand.
REQ-014 SHALL have port rf_data  input  NPORT*DW  register-file read data per port.
REQ-015 SHALL have port fwd_data  output  NPORT*DW  selected operand per port.
REQ-016 SHALL have port fwd_sel  output  NPORT*2  selected stage plus 1; 0 means rf_data.
REQ-017 SHALL have port pending  output  NPORT  match not yet ready but within tuse.
REQ-018 SHALL have port stall  output  1  freeze decode, insert bubble.
REQ-019 SHALL have port stat_stall  output  32  stall-cycle count.
REQ-020 SHALL have port stat_fwd  output  32  forwarding-event count.

Function
REQ-021 SHALL hold DEPTH entries {valid, addr, tnew}; each clock entry s moves to s+1, and entry DEPTH-1 retires.
REQ-022 SHALL decrement tnew by 1 on each move, saturating at 0.
REQ-023 SHALL load stage 0 from issue_* when issue_valid=1, stall=0, flush=0 and issue_addr!=0; otherwise stage 0 SHALL receive a bubble (valid=0).
REQ-024 SHALL, on flush=1, make every entry invalid at the next edge; flush SHALL win over stall and issue.
REQ-025 SHALL, per port, select the youngest valid entry with addr==rd_addr; rd_addr==0 SHALL never match.
REQ-026 SHALL, on a match with tnew==0, drive fwd_data=stg_data[s] and fwd_sel=s+1.
REQ-027 SHALL, on a match with 0<tnew<=tuse, drive pending=1, fwd_sel=0 and fwd_data=rf_data.
REQ-028 SHALL assert stall combinationally if any port matches with tnew>tuse.
REQ-029 SHALL not let an older ready entry override a younger unready match.
REQ-030 SHALL give fwd_data, fwd_sel and pending zero latency (combinational on current state and inputs).
REQ-031 SHALL not stall entries on stall; they keep advancing, so a hazard clears in at most 3 cycles.

Reset
REQ-032 SHALL, while reset=0, make all entries invalid, giving stall=0, pending=0, fwd_sel=0 and fwd_data=rf_data.
REQ-033 SHALL, while reset=0, hold stat_stall=0 and stat_fwd=0.
REQ-034 SHALL let reset asserted mid-operation take effect immediately, without waiting for clk.

Configuration
REQ-035 SHALL, with FWD_STATS_EN defined, increment stat_stall on each cycle with stall=1.
REQ-036 SHALL, with FWD_STATS_EN defined, increment stat_fwd by the number of ports with fwd_sel!=0 in that cycle.
REQ-037 SHALL make both counters wrap modulo 2^32 when FWD_STATS_EN is defined.
REQ-038 SHALL, with FWD_STATS_EN undefined, tie both counters to 0 and synthesise no counter flops.

Verification
REQ-039 SHALL cover: issue addr=8, tnew=0; next cycle rd_addr0=8, stg_data[0]=0x1234 -> fwd_sel0=1, fwd_data0=0x1234, stall=0.
REQ-040 SHALL cover: load issue addr=9, tnew=2; next cycle rd_addr0=9, tuse=0 -> stall=1 for 1 cycle, then fwd_sel0=2 with data from stage 1.
REQ-041 SHALL cover: stages 0 and 1 both addr=10, stage 0 tnew=1, tuse=1 -> pending0=1 and fwd_sel0=0, never stage-1 data.
REQ-042 SHALL cover: issue addr=0, tnew=0, then rd_addr0=0 -> fwd_sel0=0, fwd_data0=rf_data0.
REQ-043 SHALL cover: three hazard-causing issues, then flush=1 and stall=1 in the same cycle -> all matches gone next cycle and stall=0.
REQ-044 SHALL cover, with FWD_STATS_EN: 5 stall cycles and 3 dual-port forwards -> stat_stall=5, stat_fwd=6; then reset pulse low -> both 0 immediately.
